// File: rtl/ex_muldiv_stage.sv
// EX stage: operand forwarding, ALU, branch target and destination select,
// plus an iterative radix-2 multiply/divide unit that owns the HI/LO registers.

module alu #(
    parameter int BITS_SIZE = 32,
    parameter int BITS_OP   = 4,
    parameter int BITS_REGS = 5
) (
    input  logic [BITS_SIZE-1:0] i_a,
    input  logic [BITS_SIZE-1:0] i_b,
    input  logic [BITS_REGS-1:0] i_shamt,
    input  logic                 i_flag_shamt,
    input  logic [BITS_OP-1:0]   i_op,
    output logic                 o_zero,
    output logic [BITS_SIZE-1:0] o_result
);
    logic signed [BITS_SIZE-1:0] a_s;
    logic signed [BITS_SIZE-1:0] b_s;
    logic        [BITS_REGS-1:0] amt;

    assign a_s = i_a;
    assign b_s = i_b;
    // Shifts take either the instruction shamt field or the low bits of rs.
    assign amt = i_flag_shamt ? i_shamt : i_a[BITS_REGS-1:0];

    always_comb begin
        o_result = '0;
        case (i_op)
            BITS_OP'(0):  o_result = i_a + i_b;
            BITS_OP'(1):  o_result = i_a - i_b;
            BITS_OP'(2):  o_result = i_a & i_b;
            BITS_OP'(3):  o_result = i_a | i_b;
            BITS_OP'(4):  o_result = i_a ^ i_b;
            BITS_OP'(5):  o_result = ~(i_a | i_b);
            BITS_OP'(6):  o_result = (a_s < b_s) ? BITS_SIZE'(1) : '0;
            BITS_OP'(7):  o_result = (i_a < i_b) ? BITS_SIZE'(1) : '0;
            BITS_OP'(8):  o_result = i_b << amt;
            BITS_OP'(9):  o_result = i_b >> amt;
            BITS_OP'(10): o_result = b_s >>> amt;
            BITS_OP'(11): o_result = i_b << (BITS_SIZE / 2);
            default:      o_result = '0;
        endcase
    end

    assign o_zero = (o_result == '0);
endmodule

module ex_muldiv_stage #(
    parameter int BITS_SIZE          = 32,
    parameter int BITS_OP            = 4,
    parameter int BITS_REGS          = 5,
    parameter int BITS_CORTOCIRCUITO = 3,
    parameter int BITS_MDOP          = 4
) (
    input  logic                          i_clk,
    input  logic                          i_reset,
    input  logic [BITS_SIZE-1:0]          i_id_extension,
    input  logic [BITS_SIZE-1:0]          i_id_pc4,
    input  logic [BITS_REGS-1:0]          i_alu_shamt,
    input  logic                          i_flag_shamt,
    input  logic [BITS_OP-1:0]            i_alu_op,
    input  logic [BITS_CORTOCIRCUITO-1:0] i_corto_register_A,
    input  logic [BITS_CORTOCIRCUITO-1:0] i_corto_register_B,
    input  logic [BITS_SIZE-1:0]          i_register1,
    input  logic [BITS_SIZE-1:0]          i_register2,
    input  logic [BITS_SIZE-1:0]          i_exmem_register,
    input  logic [BITS_SIZE-1:0]          i_wb_data_write,
    input  logic                          i_idex_ctl_alu_src,
    input  logic                          i_ctl_select_reg_rd,
    input  logic [BITS_REGS-1:0]          i_rt,
    input  logic [BITS_REGS-1:0]          i_rd,
    input  logic [BITS_MDOP-1:0]          i_md_op,
    output logic [BITS_SIZE-1:0]          o_sum_pc_branch,
    output logic [BITS_SIZE-1:0]          o_data_register_A,
    output logic [BITS_SIZE-1:0]          o_data_register_B,
    output logic                          o_alu_zero,
    output logic [BITS_SIZE-1:0]          o_alu_result,
    output logic [BITS_REGS-1:0]          o_mux_register_rd,
    output logic                          o_md_busy,
    output logic                          o_md_stall
);
    localparam int W = BITS_SIZE;
    localparam logic [BITS_CORTOCIRCUITO-1:0] FWD_EXMEM = BITS_CORTOCIRCUITO'(1);
    localparam logic [BITS_CORTOCIRCUITO-1:0] FWD_WB    = BITS_CORTOCIRCUITO'(2);
    localparam logic [BITS_MDOP-1:0] MD_MULT  = BITS_MDOP'(1);
    localparam logic [BITS_MDOP-1:0] MD_MULTU = BITS_MDOP'(2);
    localparam logic [BITS_MDOP-1:0] MD_DIV   = BITS_MDOP'(3);
    localparam logic [BITS_MDOP-1:0] MD_DIVU  = BITS_MDOP'(4);
    localparam logic [BITS_MDOP-1:0] MD_MFHI  = BITS_MDOP'(5);
    localparam logic [BITS_MDOP-1:0] MD_MFLO  = BITS_MDOP'(6);
    localparam logic [BITS_MDOP-1:0] MD_MTHI  = BITS_MDOP'(7);
    localparam logic [BITS_MDOP-1:0] MD_MTLO  = BITS_MDOP'(8);
    localparam logic [W-1:0] ONES    = '1;
    localparam logic [W-1:0] ONE     = W'(1);
    localparam logic [W-1:0] LAST    = W'(W - 1);
    localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX} state_t;

    function automatic logic [W-1:0] abs_val(input logic signed [W-1:0] x);
        return (x < 0) ? W'(-x) : W'(x);
    endfunction

    function automatic logic [W-1:0] neg_if(input logic [W-1:0] x, input logic n);
        return n ? (~x + ONE) : x;
    endfunction

    function automatic logic [2*W-1:0] neg_if2(input logic [2*W-1:0] x, input logic n);
        return n ? (~x + (2*W)'(1)) : x;
    endfunction

    state_t          state;
    logic [W-1:0]    cnt;
    logic [W-1:0]    hi;
    logic [W-1:0]    lo;
    logic [2*W-1:0]  acc;
    logic [W-1:0]    b_mag;
    logic [W-1:0]    a_orig;
    logic            md_div;
    logic            neg_q;
    logic            neg_r;
    logic            div_zero;
    logic            div_ovf;

    logic [W-1:0]    fwd_a;
    logic [W-1:0]    fwd_b;
    logic [W-1:0]    alu_b;
    logic [W-1:0]    alu_res;
    logic            alu_zero;
    logic            md_idle;
    logic            md_start;
    logic            md_signed;
    logic            md_valid;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_next;
    logic [W:0]      div_trial;
    logic [2*W-1:0]  div_next;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    fix_hi;
    logic [W-1:0]    fix_lo;

    always_comb begin
        fwd_a = i_register1;
        if (i_corto_register_A == FWD_EXMEM)   fwd_a = i_exmem_register;
        else if (i_corto_register_A == FWD_WB) fwd_a = i_wb_data_write;
        fwd_b = i_register2;
        if (i_corto_register_B == FWD_EXMEM)   fwd_b = i_exmem_register;
        else if (i_corto_register_B == FWD_WB) fwd_b = i_wb_data_write;
    end

    assign alu_b             = i_idex_ctl_alu_src ? i_id_extension : fwd_b;
    assign o_data_register_A = fwd_a;
    assign o_data_register_B = fwd_b;
    assign o_sum_pc_branch   = i_id_pc4 + (i_id_extension << 2);
    assign o_mux_register_rd = i_ctl_select_reg_rd ? i_rd : i_rt;

    alu #(
        .BITS_SIZE (BITS_SIZE),
        .BITS_OP   (BITS_OP),
        .BITS_REGS (BITS_REGS)
    ) u_alu (
        .i_a          (fwd_a),
        .i_b          (alu_b),
        .i_shamt      (i_alu_shamt),
        .i_flag_shamt (i_flag_shamt),
        .i_op         (i_alu_op),
        .o_zero       (alu_zero),
        .o_result     (alu_res)
    );

    assign md_idle   = (state == ST_IDLE);
    assign md_start  = md_idle && (i_md_op >= MD_MULT) && (i_md_op <= MD_DIVU);
    assign md_signed = (i_md_op == MD_MULT) || (i_md_op == MD_DIV);
    assign md_valid  = (i_md_op >= MD_MULT) && (i_md_op <= MD_MTLO);
    assign o_md_busy  = !md_idle;
    assign o_md_stall = o_md_busy && md_valid;

    // MFHI/MFLO are only honoured once the unit is idle; while busy they stall.
    always_comb begin
        o_alu_result = alu_res;
        o_alu_zero   = alu_zero;
        if (md_idle && i_md_op == MD_MFHI) begin
            o_alu_result = hi;
            o_alu_zero   = (hi == '0);
        end else if (md_idle && i_md_op == MD_MFLO) begin
            o_alu_result = lo;
            o_alu_zero   = (lo == '0);
        end
    end

    // acc holds {partial, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin
        mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? b_mag : '0)};
        mul_next  = {mul_sum, acc[W-1:1]};
        div_trial = {acc[2*W-1:W], acc[W-1]} - {1'b0, b_mag};
        if (!div_trial[W]) div_next = {div_trial[W-1:0], acc[W-2:0], 1'b1};
        else               div_next = {acc[2*W-2:0], 1'b0};
    end

    always_comb begin
        prod_fix = neg_if2(acc, neg_q);
        fix_hi   = prod_fix[2*W-1:W];
        fix_lo   = prod_fix[W-1:0];
        if (md_div) begin
            if (div_zero) begin
                fix_hi = a_orig;
                fix_lo = ONES;
            end else if (div_ovf) begin
                fix_hi = '0;
                fix_lo = MIN_NEG;
            end else begin
                fix_hi = neg_if(acc[2*W-1:W], neg_r);
                fix_lo = neg_if(acc[W-1:0], neg_q);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (md_start) begin
                        cnt   <= '0;
                        state <= ST_RUN;
                    end else if (i_md_op == MD_MTHI) begin
                        hi <= fwd_a;
                    end else if (i_md_op == MD_MTLO) begin
                        lo <= fwd_a;
                    end
                end
                ST_RUN: begin
                    cnt <= cnt + ONE;
                    if (cnt == LAST) state <= ST_FIX;
                end
                ST_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand/datapath registers carry no reset; they are always loaded at start.
    always_ff @(posedge i_clk) begin
        if (md_start) begin
            acc      <= {{W{1'b0}}, (md_signed ? abs_val(fwd_a) : fwd_a)};
            b_mag    <= md_signed ? abs_val(fwd_b) : fwd_b;
            a_orig   <= fwd_a;
            md_div   <= (i_md_op == MD_DIV) || (i_md_op == MD_DIVU);
            neg_q    <= md_signed && (fwd_a[W-1] ^ fwd_b[W-1]);
            neg_r    <= md_signed && fwd_a[W-1];
            div_zero <= (fwd_b == '0);
            div_ovf  <= (i_md_op == MD_DIV) && (fwd_a == MIN_NEG) && (fwd_b == ONES);
        end else if (state == ST_RUN) begin
            acc <= md_div ? div_next : mul_next;
        end
    end
endmodule

// File: tb/tb_ex_muldiv_stage.sv
// Bench for ex_muldiv_stage: cycle-level reference model plus directed vectors.

module tb_ex_muldiv_stage;
    logic        i_clk = 1'b0;
    logic        i_reset;
    logic [31:0] i_id_extension, i_id_pc4;
    logic [4:0]  i_alu_shamt;
    logic        i_flag_shamt;
    logic [3:0]  i_alu_op;
    logic [2:0]  i_corto_register_A, i_corto_register_B;
    logic [31:0] i_register1, i_register2, i_exmem_register, i_wb_data_write;
    logic        i_idex_ctl_alu_src, i_ctl_select_reg_rd;
    logic [4:0]  i_rt, i_rd;
    logic [3:0]  i_md_op;
    logic [31:0] o_sum_pc_branch, o_data_register_A, o_data_register_B, o_alu_result;
    logic        o_alu_zero, o_md_busy, o_md_stall;
    logic [4:0]  o_mux_register_rd;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    // Reference model state: HI/LO and cycles remaining until the pending result lands.
    logic [31:0] m_hi = 0, m_lo = 0, m_pend_hi = 0, m_pend_lo = 0;
    int          m_busy = 0;

    ex_muldiv_stage dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_id_extension(i_id_extension), .i_id_pc4(i_id_pc4),
        .i_alu_shamt(i_alu_shamt), .i_flag_shamt(i_flag_shamt), .i_alu_op(i_alu_op),
        .i_corto_register_A(i_corto_register_A), .i_corto_register_B(i_corto_register_B),
        .i_register1(i_register1), .i_register2(i_register2),
        .i_exmem_register(i_exmem_register), .i_wb_data_write(i_wb_data_write),
        .i_idex_ctl_alu_src(i_idex_ctl_alu_src), .i_ctl_select_reg_rd(i_ctl_select_reg_rd),
        .i_rt(i_rt), .i_rd(i_rd), .i_md_op(i_md_op),
        .o_sum_pc_branch(o_sum_pc_branch), .o_data_register_A(o_data_register_A),
        .o_data_register_B(o_data_register_B), .o_alu_zero(o_alu_zero),
        .o_alu_result(o_alu_result), .o_mux_register_rd(o_mux_register_rd),
        .o_md_busy(o_md_busy), .o_md_stall(o_md_stall)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fwd(input logic [2:0] sel, input logic [31:0] r);
        if (sel == 3'd1) return i_exmem_register;
        if (sel == 3'd2) return i_wb_data_write;
        return r;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sh,
                                            input logic fl);
        int unsigned n;
        n = fl ? sh : a[4:0];
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return ~(a | b);
            4'd6:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd7:  return (a < b) ? 32'd1 : 32'd0;
            4'd8:  return b << n;
            4'd9:  return b >> n;
            4'd10: return $signed(b) >>> n;
            4'd11: return {b[15:0], 16'h0};
            default: return 32'd0;
        endcase
    endfunction

    // Model advance: plain 64-bit arithmetic decides the result, a countdown decides when.
    always @(posedge i_clk) begin
        logic [31:0] fa, fb;
        logic [63:0] p;
        fa = fwd(i_corto_register_A, i_register1);
        fb = fwd(i_corto_register_B, i_register2);
        if (i_reset) begin
            m_hi = 0; m_lo = 0; m_busy = 0;
        end else if (m_busy > 0) begin
            m_busy--;
            if (m_busy == 0) begin m_hi = m_pend_hi; m_lo = m_pend_lo; end
        end else if (i_md_op >= 4'd1 && i_md_op <= 4'd4) begin
            m_busy = 33;
            case (i_md_op)
                4'd1: begin
                    p = longint'($signed(fa)) * longint'($signed(fb));
                    m_pend_hi = p[63:32]; m_pend_lo = p[31:0];
                end
                4'd2: begin
                    p = {32'd0, fa} * {32'd0, fb};
                    m_pend_hi = p[63:32]; m_pend_lo = p[31:0];
                end
                4'd3: begin
                    if (fb == 0) begin m_pend_lo = 32'hFFFFFFFF; m_pend_hi = fa; end
                    else if (fa == 32'h80000000 && fb == 32'hFFFFFFFF) begin
                        m_pend_lo = 32'h80000000; m_pend_hi = 0;
                    end else begin
                        m_pend_lo = $signed(fa) / $signed(fb);
                        m_pend_hi = $signed(fa) % $signed(fb);
                    end
                end
                default: begin
                    if (fb == 0) begin m_pend_lo = 32'hFFFFFFFF; m_pend_hi = fa; end
                    else begin m_pend_lo = fa / fb; m_pend_hi = fa % fb; end
                end
            endcase
        end else if (i_md_op == 4'd7) m_hi = fa;
        else if (i_md_op == 4'd8) m_lo = fa;
    end

    always @(negedge i_clk) begin
        logic [31:0] fa, fb, er;
        logic        busy;
        if (cmp_en) begin
            fa = fwd(i_corto_register_A, i_register1);
            fb = fwd(i_corto_register_B, i_register2);
            busy = (m_busy != 0);
            if (!busy && i_md_op == 4'd5)      er = m_hi;
            else if (!busy && i_md_op == 4'd6) er = m_lo;
            else er = alu_ref(i_alu_op, fa, i_idex_ctl_alu_src ? i_id_extension : fb,
                              i_alu_shamt, i_flag_shamt);
            check("busy", {31'd0, o_md_busy}, {31'd0, busy});
            check("stall", {31'd0, o_md_stall},
                  {31'd0, busy && i_md_op >= 4'd1 && i_md_op <= 4'd8});
            check("alu_result", o_alu_result, er);
            check("alu_zero", {31'd0, o_alu_zero}, {31'd0, er == 0});
            check("fwd_A", o_data_register_A, fa);
            check("fwd_B", o_data_register_B, fb);
            check("branch", o_sum_pc_branch, i_id_pc4 + (i_id_extension << 2));
            check("rd_sel", {27'd0, o_mux_register_rd},
                  {27'd0, i_ctl_select_reg_rd ? i_rd : i_rt});
        end
    end

    task automatic tick();
        @(posedge i_clk); #1;
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        i_md_op = op; i_register1 = a; i_register2 = b;
        tick();
        i_md_op = 0;
    endtask

    task automatic read_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
        i_md_op = 4'd6;
        @(negedge i_clk); check({name, "_lo"}, o_alu_result, el);
        tick();
        i_md_op = 4'd5;
        @(negedge i_clk); check({name, "_hi"}, o_alu_result, eh);
        tick();
        i_md_op = 0;
    endtask

    task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        issue(op, a, b);
        repeat (34) tick();
        read_hilo(name, eh, el);
    endtask

    initial begin
        int n, k;
        i_reset = 1; i_id_extension = 0; i_id_pc4 = 0; i_alu_shamt = 0; i_flag_shamt = 0;
        i_alu_op = 0; i_corto_register_A = 0; i_corto_register_B = 0; i_register1 = 0;
        i_register2 = 0; i_exmem_register = 0; i_wb_data_write = 0; i_idex_ctl_alu_src = 0;
        i_ctl_select_reg_rd = 0; i_rt = 0; i_rd = 0; i_md_op = 0;
        tick();
        cmp_en = 1;
        tick();
        @(negedge i_clk);
        check("reset_busy", {31'd0, o_md_busy}, 32'd0);
        check("reset_stall", {31'd0, o_md_stall}, 32'd0);
        i_reset = 0;
        tick();
        read_hilo("reset", 32'd0, 32'd0);

        // Plain EX datapath vectors
        i_alu_op = 4'd1; i_register1 = 10; i_register2 = 3;
        @(negedge i_clk); check("sub", o_alu_result, 32'd7);
        tick(); i_register2 = 10;
        @(negedge i_clk); check("sub_zero", {31'd0, o_alu_zero}, 32'd1);
        tick(); i_alu_op = 4'd6; i_register1 = 32'hFFFFFFFF; i_register2 = 1;
        @(negedge i_clk); check("slt", o_alu_result, 32'd1);
        tick(); i_alu_op = 4'd10; i_flag_shamt = 1; i_alu_shamt = 4; i_register2 = 32'h80000000;
        @(negedge i_clk); check("sra", o_alu_result, 32'hF8000000);
        tick(); i_alu_op = 4'd0; i_flag_shamt = 0; i_idex_ctl_alu_src = 1;
        i_register1 = 100; i_id_extension = 32'hFFFFFFFC; i_id_pc4 = 32'h100;
        i_ctl_select_reg_rd = 1; i_rt = 5'd7; i_rd = 5'd19;
        @(negedge i_clk);
        check("addi", o_alu_result, 32'd96);
        check("branch_lit", o_sum_pc_branch, 32'h000000F0);
        check("rd_lit", {27'd0, o_mux_register_rd}, 32'd19);
        tick(); i_idex_ctl_alu_src = 0; i_id_extension = 0; i_ctl_select_reg_rd = 0;

        // MULT -3*7 with busy window length
        issue(4'd1, 32'hFFFFFFFD, 32'd7);
        n = 0;
        repeat (40) begin
            @(negedge i_clk); if (o_md_busy) n++;
            tick();
        end
        check("mult_busy_cycles", n, 32'd33);
        read_hilo("mult", 32'hFFFFFFFF, 32'hFFFFFFEB);

        run_op("multu", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001);
        run_op("div", 4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        run_op("divu0", 4'd4, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        run_op("div_ovf", 4'd3, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000);
        run_op("divu", 4'd4, 32'd100, 32'd7, 32'd2, 32'd14);
        run_op("div_negrem", 4'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD);

        // Independent ALU op proceeds while the unit is busy
        issue(4'd1, 32'd3, 32'd4);
        i_alu_op = 4'd0; i_register1 = 10; i_register2 = 20;
        @(negedge i_clk);
        check("add_busy_stall", {31'd0, o_md_stall}, 32'd0);
        check("add_busy_res", o_alu_result, 32'd30);
        repeat (34) tick();
        read_hilo("mult34", 32'd0, 32'd12);

        // MFLO right behind MULT stalls until the result is ready
        issue(4'd1, 32'd1234, 32'hFFFFFFFB);
        i_md_op = 4'd6;
        n = 0; k = 0;
        while (k < 60) begin
            @(negedge i_clk);
            if (!o_md_stall) break;
            n++; k++;
            tick();
        end
        check("mflo_stall_cycles", n, 32'd33);
        check("mflo_after_stall", o_alu_result, 32'hFFFFE7E6);
        tick(); i_md_op = 0;

        // Forwarded operands feed MULTU
        i_corto_register_A = 3'b001; i_exmem_register = 5;
        i_corto_register_B = 3'b010; i_wb_data_write = 9;
        i_register1 = 100; i_register2 = 200; i_md_op = 4'd2;
        @(negedge i_clk);
        check("fwd_A_lit", o_data_register_A, 32'd5);
        check("fwd_B_lit", o_data_register_B, 32'd9);
        tick(); i_md_op = 0; i_corto_register_A = 0; i_corto_register_B = 0;
        repeat (34) tick();
        read_hilo("fwd_multu", 32'd0, 32'd45);

        // Reset in the middle of RUN aborts the operation
        issue(4'd1, 32'd5, 32'd6);
        repeat (9) tick();
        i_reset = 1;
        tick();
        i_reset = 0;
        @(negedge i_clk);
        check("abort_busy", {31'd0, o_md_busy}, 32'd0);
        tick();
        read_hilo("abort", 32'd0, 32'd0);
        i_md_op = 4'd8; i_register1 = 32'h1234;
        tick(); i_md_op = 0;
        read_hilo("mtlo", 32'd0, 32'h1234);
        i_md_op = 4'd7; i_register1 = 32'hCAFE0001;
        tick(); i_md_op = 0;
        read_hilo("mthi", 32'hCAFE0001, 32'h1234);

        repeat (2) tick();
        cmp_en = 0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule

// File: doc/ex_muldiv_stage.md
# ex_muldiv_stage

Execute stage with an integrated multi-cycle multiply/divide unit and HI/LO registers. It keeps the current EX datapath: ALU operand forwarding, immediate select, rt/rd destination select and branch target adder. It adds signed/unsigned MULT/DIV, MFHI/MFLO/MTHI/MTLO and a stall output to hazard control. It sits between the ID/EX and EX/MEM pipeline registers. The existing `alu` module is reused unchanged for all non-muldiv operations.

## Interface
- BITS_SIZE, 32: datapath width; even, ≥8
- BITS_OP, 4: ALU op width (existing alu encoding)
- BITS_REGS, 5: register index / shamt width
- BITS_CORTOCIRCUITO, 3: forwarding select width
- BITS_MDOP, 4: muldiv op width

Ports:
- i_clk  in  1  clock, rising edge
- i_reset  in  1  synchronous, active-high reset
- i_id_extension, i_id_pc4  in  BITS_SIZE  sign-extended immediate, PC+4
- i_alu_shamt  in  BITS_REGS;  i_flag_shamt  in  1;  i_alu_op  in  BITS_OP  passed to alu
- i_corto_register_A, i_corto_register_B  in  BITS_CORTOCIRCUITO  forwarding selects
- i_register1, i_register2  in  BITS_SIZE  ID/EX rs, rt values
- i_exmem_register, i_wb_data_write  in  BITS_SIZE  forwarded EX/MEM and MEM/WB data
- i_idex_ctl_alu_src  in  1  1 = ALU B uses immediate
- i_ctl_select_reg_rd  in  1;  i_rt, i_rd  in  BITS_REGS  destination select
- i_md_op  in  BITS_MDOP  muldiv op of the instruction in EX
- o_sum_pc_branch  out  BITS_SIZE  i_id_pc4 + (i_id_extension << 2), mod 2^BITS_SIZE
- o_data_register_A, o_data_register_B  out  BITS_SIZE  forwarded rs, rt (B ignores alu_src)
- o_alu_zero  out  1;  o_alu_result  out  BITS_SIZE
- o_mux_register_rd  out  BITS_REGS  i_rd if i_ctl_select_reg_rd else i_rt
- o_md_busy  out  1  unit iterating
- o_md_stall  out  1  freeze PC, IF/ID and ID/EX; bubble into EX/MEM

## Operation
- Forwarding, A and B: 3'b000 register, 3'b001 i_exmem_register, 3'b010 i_wb_data_write, other codes register. The ALU B input is i_id_extension when alu_src=1, else forwarded B.
- i_md_op: 0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO. Codes 9-15 are treated as none.
- Muldiv operands are the forwarded A (rs) and B (rt), latched at start.
- FSM IDLE → RUN → FIX → IDLE.
  - IDLE: on ops 1-4, latch the operand magnitudes (signed ops take the absolute value; unsigned ops take the raw value), the result-sign flags and the op type. Clear the BITS_SIZE-bit iteration counter and go to RUN.
  - RUN: one radix-2 step per cycle. Multiply is shift-add into a 2·BITS_SIZE accumulator. Divide is restoring. After BITS_SIZE steps, go to FIX.
  - FIX: apply the two's-complement sign fix and write HI/LO, then go to IDLE.
    - MULT/MULTU: {HI,LO} = product.
    - DIV/DIVU: LO = quotient, HI = remainder. The remainder takes the sign of the dividend.
- Divide by zero: LO = all ones, HI = dividend (original, unsigned-interpreted). No exception is raised.
- Signed overflow (most-negative / −1): LO = most-negative, HI = 0.
- MTHI/MTLO in IDLE: HI/LO ← forwarded A at the clock edge.
- MFHI/MFLO in IDLE: o_alu_result = HI/LO combinationally, o_alu_zero = (result == 0). Otherwise these come from alu.
- o_md_busy = state ≠ IDLE.
- o_md_stall = o_md_busy AND i_md_op ∈ {1..8}.
  - While stalled the instruction stays in EX and is re-presented; the block ignores it until IDLE.
  - An independent instruction (op 0) proceeds while busy.

## Timing
- Reset: state IDLE, HI = LO = 0, counter 0, o_md_busy = 0, o_md_stall = 0. Reset overrides an operation in flight, and the partial result is discarded.
- Start is accepted at the edge ending the cycle (t) where IDLE and op ∈ 1-4. o_md_stall is 0 in cycle t.
- RUN occupies t+1 … t+BITS_SIZE and FIX occupies t+BITS_SIZE+1. HI/LO are updated at the end of FIX.
- MFHI in cycle t+BITS_SIZE+2 returns the new value (t+34 for 32 bits). If MFHI is presented earlier, o_md_stall = 1 through t+BITS_SIZE+1.
- Back-to-back: a second MULT presented at t+1 stalls and starts at the edge ending t+BITS_SIZE+2.
- All non-muldiv outputs are combinational, with zero cycles of latency.

## Test plan
- MULT A=−3, B=7, then MFLO/MFHI after completion → LO=0xFFFFFFEB, HI=0xFFFFFFFF. o_md_busy is high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 7/0 → LO=0xFFFFFFFF, HI=7. DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- MFLO issued one cycle after MULT → o_md_stall=1 for 33 cycles, then result valid. Meanwhile an op-0 ADD issued during busy → o_md_stall=0 with the correct ALU result.
- Forwarding: corto_A=001 with exmem=5, corto_B=010 with wb=9, MULTU → LO=45.
- i_reset asserted in RUN cycle 10 → next cycle IDLE, HI=LO=0, busy=0. A new MTLO 0x1234 then MFLO → 0x1234.
